cycle_sequencer: RTL and testbench

- Multi-cycle control sequencer for the LEGv8 datapath: PC, instruction cache, controller decode, operand prep, ALU and data cache.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, driving one-cycle enable strobes to each unit.
- Handshakes with the caches through memReq/memReady.
- Provides halt, retire count and memory-timeout error reporting.

---
 rtl/cycle_sequencer_if.sv | 45 ++++
 rtl/cycle_sequencer.sv | 152 +++++++++++++++
 tb/tb_cycle_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cycle_sequencer_if.sv
// Control bundle between the LEGv8 multi-cycle sequencer and its datapath.
// master = sequencer side, slave = datapath/cache side.
interface cycle_sequencer_if #(
   parameter int OPCODE_WIDTH = 11,
   parameter int COUNT_WIDTH  = 32
);
   logic                    run;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    memReadFlag;
   logic                    memWriteFlag;
   logic                    regWriteFlag;
   logic                    memReady;
   logic                    fetchEn;
   logic                    irLoad;
   logic                    decodeEn;
   logic                    aluEn;
   logic                    memReq;
   logic                    regWriteEn;
   logic                    pcUpdate;
   logic [2:0]              state;
   logic                    busy;
   logic                    halted;
   logic                    errorFlag;
   logic [COUNT_WIDTH-1:0]  instrCount;

   modport master (
      input  run, opcode,
      input  memReadFlag, memWriteFlag,
      input  regWriteFlag, memReady,
      output fetchEn, irLoad, decodeEn,
      output aluEn, memReq, regWriteEn,
      output pcUpdate, state, busy,
      output halted, errorFlag, instrCount
   );

   modport slave (
      output run, opcode,
      output memReadFlag, memWriteFlag,
      output regWriteFlag, memReady,
      input  fetchEn, irLoad, decodeEn,
      input  aluEn, memReq, regWriteEn,
      input  pcUpdate, state, busy,
      input  halted, errorFlag, instrCount
   );
endinterface

// File: rtl/cycle_sequencer.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// strobes, cache handshake, halt, retire count and memory timeout.
module cycle_sequencer #(
   parameter int OPCODE_WIDTH = 11,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 11'h7FF,
   parameter int WAIT_LIMIT   = 15,
   parameter int COUNT_WIDTH  = 32
) (
   input logic         clock,
   input logic         resetN,
   cycle_sequencer_if.master bus
);

   localparam int WW = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6,
      S_ERROR     = 3'd7
   } state_t;

   state_t                 r_state;
   logic [WW-1:0]          r_waitCount;
   logic [COUNT_WIDTH-1:0] r_instrCount;
   logic                   r_memRd;
   logic                   r_memWr;
   logic                   r_regWr;

   state_t                 w_next;
   logic [WW-1:0]          w_waitNext;
   logic                   w_retire;
   logic                   w_atLimit;
   logic                   w_fetchEn;
   logic                   w_irLoad;
   logic                   w_decodeEn;
   logic                   w_aluEn;
   logic                   w_memReq;
   logic                   w_regWriteEn;

   assign w_atLimit = (r_waitCount == WW'(WAIT_LIMIT - 1));

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state      <= S_IDLE;
         r_waitCount  <= '0;
         r_instrCount <= '0;
         r_memRd      <= 1'b0;
         r_memWr      <= 1'b0;
         r_regWr      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_waitCount <= w_waitNext;
         if (w_retire)
            r_instrCount <= r_instrCount + COUNT_WIDTH'(1);
         if (r_state == S_EXECUTE) begin
            r_memRd <= bus.memReadFlag;
            r_memWr <= bus.memWriteFlag;
            r_regWr <= bus.regWriteFlag;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_waitNext   = '0;
      w_retire     = 1'b0;
      w_fetchEn    = 1'b0;
      w_irLoad     = 1'b0;
      w_decodeEn   = 1'b0;
      w_aluEn      = 1'b0;
      w_memReq     = 1'b0;
      w_regWriteEn = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.run)
               w_next = S_FETCH;
         end
         S_FETCH: begin
            w_fetchEn = 1'b1;
            w_memReq  = 1'b1;
            if (bus.memReady) begin
               w_irLoad = 1'b1;
               w_next   = S_DECODE;
            end else if (w_atLimit) begin
               w_next = S_ERROR;
            end else begin
               w_waitNext = r_waitCount + WW'(1);
            end
         end
         S_DECODE: begin
            w_decodeEn = 1'b1;
            if (bus.opcode == HALT_OPCODE)
               w_next = S_HALT;
            else
               w_next = S_EXECUTE;
         end
         S_EXECUTE: begin
            w_aluEn = 1'b1;
            if (bus.memReadFlag | bus.memWriteFlag)
               w_next = S_MEMORY;
            else if (bus.regWriteFlag)
               w_next = S_WRITEBACK;
            else
               w_retire = 1'b1;
         end
         S_MEMORY: begin
            w_memReq = 1'b1;
            if (bus.memReady) begin
               // A load with a destination writes back; stores retire now
               if (r_memRd & r_regWr)
                  w_next = S_WRITEBACK;
               else
                  w_retire = 1'b1;
            end else if (w_atLimit) begin
               w_next = S_ERROR;
            end else begin
               w_waitNext = r_waitCount + WW'(1);
            end
         end
         S_WRITEBACK: begin
            w_regWriteEn = 1'b1;
            w_retire     = 1'b1;
         end
         S_HALT:  w_next = S_HALT;
         S_ERROR: w_next = S_ERROR;
         default: w_next = S_IDLE;
      endcase
      if (w_retire)
         w_next = bus.run ? S_FETCH : S_IDLE;
   end

   assign bus.fetchEn    = w_fetchEn;
   assign bus.irLoad     = w_irLoad;
   assign bus.decodeEn   = w_decodeEn;
   assign bus.aluEn      = w_aluEn;
   assign bus.memReq     = w_memReq;
   assign bus.regWriteEn = w_regWriteEn;
   assign bus.pcUpdate   = w_retire;
   assign bus.state      = r_state;
   assign bus.busy       = (r_state != S_IDLE) &&
                           (r_state != S_HALT) &&
                           (r_state != S_ERROR);
   assign bus.halted     = (r_state == S_HALT);
   assign bus.errorFlag  = (r_state == S_ERROR);
   assign bus.instrCount = r_instrCount;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: vector table plus
// hand sequences for timeout, limit pulse, run drop and reset.
module tb_cycle_sequencer;

   localparam int OW = 11;
   localparam int CW = 32;

   localparam logic [OW-1:0] OP_R    = 11'h458;
   localparam logic [OW-1:0] OP_CBZ  = 11'h5A0;
   localparam logic [OW-1:0] OP_STUR = 11'h7C0;
   localparam logic [OW-1:0] OP_LDUR = 11'h7C2;
   localparam logic [OW-1:0] OP_HALT = 11'h7FF;

   logic clock  = 1'b0;
   logic resetN = 1'b0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   always #5 clock = ~clock;

   cycle_sequencer_if #(
      .OPCODE_WIDTH(OW),
      .COUNT_WIDTH(CW)
   ) bus ();

   cycle_sequencer #(
      .OPCODE_WIDTH(OW),
      .HALT_OPCODE(OP_HALT),
      .WAIT_LIMIT(15),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock(clock),
      .resetN(resetN),
      .bus(bus)
   );

   // outs = {fetchEn,irLoad,decodeEn,aluEn,memReq,regWriteEn,pcUpdate,halted,errorFlag}
   typedef struct {
      logic          run;
      logic [OW-1:0] op;
      logic          rd, wr, rw, mr;
      logic [2:0]    st;
      logic [8:0]    outs;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tbl [27];

   function automatic logic [8:0] outs_now();
      return {bus.fetchEn, bus.irLoad, bus.decodeEn,
              bus.aluEn, bus.memReq, bus.regWriteEn,
              bus.pcUpdate, bus.halted, bus.errorFlag};
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic run, input logic [OW-1:0] op,
                        input logic rd, input logic wr,
                        input logic rw, input logic mr);
      bus.run          = run;
      bus.opcode       = op;
      bus.memReadFlag  = rd;
      bus.memWriteFlag = wr;
      bus.regWriteFlag = rw;
      bus.memReady     = mr;
   endtask

   task automatic step(input logic run, input logic [OW-1:0] op,
                       input logic rd, input logic wr,
                       input logic rw, input logic mr);
      @(posedge clock);
      #1;
      drive(run, op, rd, wr, rw, mr);
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetN = 1'b0;
      drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      resetN = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{1, OP_R,    0,0,0,1, 3'd0, 9'b0_0_0_0_0_0_0_0_0, 0};
      tbl[1]  = '{1, OP_R,    0,0,0,1, 3'd1, 9'b1_1_0_0_1_0_0_0_0, 0};
      tbl[2]  = '{1, OP_R,    0,0,0,1, 3'd2, 9'b0_0_1_0_0_0_0_0_0, 0};
      tbl[3]  = '{1, OP_R,    0,0,1,1, 3'd3, 9'b0_0_0_1_0_0_0_0_0, 0};
      tbl[4]  = '{1, OP_R,    0,0,0,1, 3'd5, 9'b0_0_0_0_0_1_1_0_0, 0};
      tbl[5]  = '{1, OP_CBZ,  0,0,0,1, 3'd1, 9'b1_1_0_0_1_0_0_0_0, 1};
      tbl[6]  = '{1, OP_CBZ,  0,0,0,1, 3'd2, 9'b0_0_1_0_0_0_0_0_0, 1};
      tbl[7]  = '{1, OP_CBZ,  0,0,0,1, 3'd3, 9'b0_0_0_1_0_0_1_0_0, 1};
      tbl[8]  = '{1, OP_STUR, 0,0,0,1, 3'd1, 9'b1_1_0_0_1_0_0_0_0, 2};
      tbl[9]  = '{1, OP_STUR, 0,0,0,1, 3'd2, 9'b0_0_1_0_0_0_0_0_0, 2};
      tbl[10] = '{1, OP_STUR, 0,1,0,1, 3'd3, 9'b0_0_0_1_0_0_0_0_0, 2};
      tbl[11] = '{1, OP_STUR, 0,0,0,1, 3'd4, 9'b0_0_0_0_1_0_1_0_0, 2};
      tbl[12] = '{1, OP_LDUR, 0,0,0,1, 3'd1, 9'b1_1_0_0_1_0_0_0_0, 3};
      tbl[13] = '{1, OP_LDUR, 0,0,0,1, 3'd2, 9'b0_0_1_0_0_0_0_0_0, 3};
      tbl[14] = '{1, OP_LDUR, 1,0,1,1, 3'd3, 9'b0_0_0_1_0_0_0_0_0, 3};
      tbl[15] = '{1, OP_LDUR, 0,0,0,0, 3'd4, 9'b0_0_0_0_1_0_0_0_0, 3};
      tbl[16] = '{1, OP_LDUR, 0,0,0,0, 3'd4, 9'b0_0_0_0_1_0_0_0_0, 3};
      tbl[17] = '{1, OP_LDUR, 0,0,0,0, 3'd4, 9'b0_0_0_0_1_0_0_0_0, 3};
      tbl[18] = '{1, OP_LDUR, 0,0,0,1, 3'd4, 9'b0_0_0_0_1_0_0_0_0, 3};
      tbl[19] = '{0, OP_LDUR, 0,0,0,1, 3'd5, 9'b0_0_0_0_0_1_1_0_0, 3};
      tbl[20] = '{0, OP_R,    0,0,0,1, 3'd0, 9'b0_0_0_0_0_0_0_0_0, 4};
      tbl[21] = '{0, OP_R,    0,0,0,1, 3'd0, 9'b0_0_0_0_0_0_0_0_0, 4};
      tbl[22] = '{1, OP_HALT, 0,0,0,1, 3'd0, 9'b0_0_0_0_0_0_0_0_0, 4};
      tbl[23] = '{1, OP_HALT, 0,0,0,1, 3'd1, 9'b1_1_0_0_1_0_0_0_0, 4};
      tbl[24] = '{1, OP_HALT, 0,0,0,1, 3'd2, 9'b0_0_1_0_0_0_0_0_0, 4};
      tbl[25] = '{0, OP_HALT, 0,0,0,1, 3'd6, 9'b0_0_0_0_0_0_0_1_0, 4};
      tbl[26] = '{1, OP_HALT, 0,0,0,1, 3'd6, 9'b0_0_0_0_0_0_0_1_0, 4};

      drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      #12;
      chk("reset", 64'({bus.state, outs_now(), bus.busy, bus.instrCount}),
          64'({3'd0, 9'd0, 1'b0, 32'd0}));
      resetN = 1'b1;

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].run, tbl[i].op, tbl[i].rd,
              tbl[i].wr, tbl[i].rw, tbl[i].mr);
         chk($sformatf("vec%0d", i),
             64'({bus.state, outs_now(), bus.busy, bus.instrCount}),
             64'({tbl[i].st, tbl[i].outs,
                  (tbl[i].st >= 3'd1 && tbl[i].st <= 3'd5),
                  tbl[i].cnt}));
      end

      // fetch timeout: 15 memReady-low FETCH cycles then ERROR
      do_reset();
      step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("to_idle", 64'(bus.state), 64'(0));
      for (int i = 1; i <= 15; i++) begin
         step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("to_wait%0d", i), 64'(bus.state), 64'(1));
      end
      step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("to_err", 64'({bus.state, outs_now(), bus.busy}),
          64'({3'd7, 9'b0_0_0_0_0_0_0_0_1, 1'b0}));
      step(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("to_sticky", 64'({bus.state, bus.errorFlag}), 64'({3'd7, 1'b1}));

      // reset asserted mid MEMORY
      do_reset();
      step(1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, OP_LDUR, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, OP_LDUR, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rm_mem", 64'({bus.state, bus.memReq}), 64'({3'd4, 1'b1}));
      resetN = 1'b0;
      #1;
      chk("rm_rst", 64'({bus.state, bus.memReq, bus.instrCount}),
          64'({3'd0, 1'b0, 32'd0}));

      // memReady on the limit cycle wins over timeout
      do_reset();
      step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 14; i++)
         step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lim_fetch", 64'({bus.state, outs_now()}),
          64'({3'd1, 9'b1_1_0_0_1_0_0_0_0}));
      step(1'b1, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lim_dec", 64'({bus.state, bus.errorFlag}), 64'({3'd2, 1'b0}));

      // run dropped during EXECUTE: writeback finishes, then IDLE
      step(1'b0, OP_R, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("rd_exe", 64'(bus.state), 64'(3));
      step(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rd_wb", 64'({bus.state, outs_now()}),
          64'({3'd5, 9'b0_0_0_0_0_1_1_0_0}));
      step(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rd_idle", 64'({bus.state, bus.instrCount}),
          64'({3'd0, 32'd1}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
